// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Run-time loader for the instruction store. Collects a byte stream
//   (least significant byte first) into 32-bit words and writes them into the
//   store. Fetch is held for the whole load. On a complete load, fetch is
//   redirected to BOOT_ADDR with a one-cycle jump pulse.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   load_start      one-cycle request. Only looked at while idle.
//   load_len        number of words to load, captured with load_start
//   load_abort      abandons a load that is in progress
//   byte_vld/_data  byte source. A byte transfers when byte_vld & byte_rdy.
//   byte_rdy        ready for a byte (receive phase only)
//   imem_we/waddr/wdata   write port of the instruction store
//   core_hold       freezes the fetch pc while a load is in progress
//   core_jmp_vld/addr     one-cycle redirect of fetch to BOOT_ADDR
//   load_busy       high whenever the loader is not idle
//   load_done       one-cycle pulse when a load completes (with the jump)
//   load_err        one-cycle pulse when a load is rejected or aborted
module imem_boot_loader #(
    parameter int unsigned DEPTH_BITS = 12,
    parameter logic [31:0] BOOT_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [DEPTH_BITS-2:0] load_len,
    input  logic                  load_abort,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_data,
    output logic                  byte_rdy,
    output logic                  imem_we,
    output logic [DEPTH_BITS-3:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  core_jmp_vld,
    output logic [31:0]           core_jmp_addr,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    // Full store depth in words. It is the largest legal load_len.
    localparam logic [DEPTH_BITS-2:0] MAX_WORDS = {1'b1, {(DEPTH_BITS-2){1'b0}}};
    localparam logic [DEPTH_BITS-2:0] WORD_ONE  = {{(DEPTH_BITS-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RECV    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                state;
    logic [DEPTH_BITS-2:0] len_q;
    logic [DEPTH_BITS-2:0] wcnt;
    logic [DEPTH_BITS-2:0] wcnt_nxt;
    logic [1:0]            bcnt;
    logic [31:0]           shreg;
    logic                  we_q;
    logic                  abort_now;

    assign wcnt_nxt  = wcnt + WORD_ONE;
    assign abort_now = load_abort &&
                       ((state == DRAIN) || (state == RECV) || (state == WRITE));

    // The write strobe is registered. An abort that arrives during the write
    // cycle must still cancel that write, so the abort gates the strobe here.
    assign imem_we       = we_q & ~load_abort;
    assign imem_waddr    = wcnt[DEPTH_BITS-3:0];
    assign imem_wdata    = shreg;
    assign core_jmp_addr = BOOT_ADDR;
    assign load_busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            wcnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            we_q         <= 1'b0;
            byte_rdy     <= 1'b0;
            core_hold    <= 1'b0;
            core_jmp_vld <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            core_jmp_vld <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;

            if (abort_now) begin
                // Discard the partial word. Words already written stay in the store.
                state     <= IDLE;
                bcnt      <= '0;
                byte_rdy  <= 1'b0;
                core_hold <= 1'b0;
                load_err  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_start) begin
                            if ((load_len == '0) || (load_len > MAX_WORDS)) begin
                                load_err <= 1'b1;
                            end else begin
                                len_q     <= load_len;
                                wcnt      <= '0;
                                bcnt      <= '0;
                                shreg     <= '0;
                                core_hold <= 1'b1;
                                state     <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        byte_rdy <= 1'b1;
                        state    <= RECV;
                    end
                    RECV: begin
                        if (byte_vld) begin
                            shreg[{bcnt, 3'b000} +: 8] <= byte_data;
                            bcnt <= bcnt + 2'd1;
                            if (bcnt == 2'd3) begin
                                byte_rdy <= 1'b0;
                                we_q     <= 1'b1;
                                state    <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        wcnt <= wcnt_nxt;
                        if (wcnt_nxt == len_q) begin
                            core_jmp_vld <= 1'b1;
                            load_done    <= 1'b1;
                            state        <= RELEASE;
                        end else begin
                            byte_rdy <= 1'b1;
                            state    <= RECV;
                        end
                    end
                    RELEASE: begin
                        core_hold <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        core_hold <= 1'b0;
                        byte_rdy  <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
